// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the streaming UART transmitter.
//   - parity_mode encodings (PAR_NONE / PAR_ODD / PAR_EVEN; 2'b11 also means none)
//   - transmitter FSM state enum (BREAK only exists with UART_TX_BREAK_EN)
//   - frame_cfg_t: per-frame settings latched when a word is loaded
//   - bps_cnt(): sys_clk cycles per bit
// Optional feature macro: UART_TX_BREAK_EN
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Break length in bit times: two 8N1 frames low (the high stop time follows).
  localparam int BREAK_BITS = 20;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,BREAK = 3'd5
`endif
  } tx_state_e;

  typedef struct packed {
    logic [1:0] par_mode;
    logic       stop2;
  } frame_cfg_t;

  function automatic int bps_cnt(input int clk, input int bps);
    return clk / bps;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO, first-word-not-fall-through.
//   dout is registered and updates on the edge that pops; it holds until the
//   next pop. Push while full and pop while empty are ignored.
// Ports:
//   sys_clk, sys_rst_n  clock, async active-low reset
//   push, din           write request / data
//   pop, dout           read request / registered read data
//   full, empty, level  status; level is the occupancy 0..DEPTH
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: FIFO-buffered UART transmitter, LSB first, back-to-back
// frames with no idle gap.
// Ports:
//   sys_clk, sys_rst_n   clock, async active-low reset
//   tx_valid/tx_data     word from the source, accepted when tx_ready is high
//   tx_ready             FIFO not full
//   parity_mode          00 none, 01 odd, 10 even, 11 none (latched per frame)
//   stop2                1 = two stop bits (latched per frame)
//   fifo_level           FIFO occupancy
//   tx_busy              frame in progress or FIFO non-empty
//   uart_txd             serial line, registered, idles high
//   send_break           (UART_TX_BREAK_EN only) request a line break from IDLE
// Optional feature macro: UART_TX_BREAK_EN
module uart_tx_stream import uart_pkg::*; #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                          send_break,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          uart_txd
);

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int TW      = $clog2(BPS_CNT);
  localparam int IW      = $clog2(DATA_BITS + 1);

  tx_state_e              state, nstate;
  frame_cfg_t             cfg;
  logic [TW-1:0]          bit_tmr;
  logic [IW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg, fifo_dout;
  logic                   par_bit;
  logic                   txd_nxt;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic                   bit_end, last_data, last_stop;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (tx_valid),
    .pop       (fifo_pop),
    .din       (tx_data),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (state != IDLE) || (fifo_level != '0);

  assign bit_end   = (bit_tmr == TW'(BPS_CNT - 1));
  assign last_data = bit_end && (bit_idx == IW'(DATA_BITS - 1));
  assign last_stop = bit_end && (bit_idx == (cfg.stop2 ? IW'(1) : IW'(0)));

`ifdef UART_TX_BREAK_EN
  logic [4:0] brk_cnt;
  logic       brk_last;
  assign brk_last = bit_end && (brk_cnt == 5'(BREAK_BITS));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)          brk_cnt <= '0;
    else if (state != BREAK) brk_cnt <= '0;
    else if (bit_end)        brk_cnt <= brk_cnt + 5'd1;
  end
`endif

  // Next state / pop / line value. uart_txd is registered from the current
  // state, so the line lags the FSM by one cycle; every state therefore keeps
  // its full BPS_CNT duration on the pin.
  always_comb begin
    nstate   = state;
    fifo_pop = 1'b0;
    txd_nxt  = 1'b1;
    case (state)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (send_break) nstate = BREAK;
        else
`endif
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          nstate   = START;
        end
      end
      START: begin
        txd_nxt = 1'b0;
        if (bit_end) nstate = DATA;
      end
      DATA: begin
        txd_nxt = shreg[0];
        if (last_data)
          nstate = (cfg.par_mode == PAR_ODD || cfg.par_mode == PAR_EVEN) ? PARITY : STOP;
      end
      PARITY: begin
        txd_nxt = par_bit;
        if (bit_end) nstate = STOP;
      end
      STOP: begin
        if (last_stop) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            nstate   = START;
          end else begin
            nstate = IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        txd_nxt = (brk_cnt == 5'(BREAK_BITS));
        if (brk_last) nstate = IDLE;
      end
`endif
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cfg      <= '0;
      bit_tmr  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      uart_txd <= 1'b1;
    end else begin
      state    <= nstate;
      uart_txd <= txd_nxt;

      // Frame settings are sampled only at load, so mid-frame changes wait.
      if (fifo_pop) begin
        cfg.par_mode <= parity_mode;
        cfg.stop2    <= stop2;
      end

      if (state == IDLE || bit_end) bit_tmr <= '0;
      else                          bit_tmr <= bit_tmr + TW'(1);

      if (state != nstate) bit_idx <= '0;
      else if (bit_end)    bit_idx <= bit_idx + IW'(1);

      // The FIFO read data becomes valid the cycle after the pop, so the
      // shift register is loaded at the end of the start bit.
      if (state == START && bit_end) begin
        shreg   <= fifo_dout;
        par_bit <= (cfg.par_mode == PAR_EVEN) ? ^fifo_dout : ~^fifo_dout;
      end else if (state == DATA && bit_end) begin
        shreg <= shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed, table-driven bench for uart_tx_stream
// (BPS_CNT = 10, 8 data bits, 16-deep FIFO). Line expectations are written as
// hand-computed per-slot bit patterns: bit i of 'line' is the level of bit
// time i of the frame (start, data LSB first, optional parity, stop(s)).
module tb_uart_tx_stream;

  localparam int BPS = 10;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] parity_mode = 2'b00;
  logic       stop2 = 1'b0;
  logic       tx_ready, tx_busy, uart_txd;
  logic [4:0] fifo_level;
`ifdef UART_TX_BREAK_EN
  logic       send_break = 1'b0;
`endif

  always #5 sys_clk = ~sys_clk;

  uart_tx_stream #(
    .CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(8), .FIFO_DEPTH(16)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .parity_mode (parity_mode),
    .stop2       (stop2),
`ifdef UART_TX_BREAK_EN
    .send_break  (send_break),
`endif
    .fifo_level  (fifo_level),
    .tx_busy     (tx_busy),
    .uart_txd    (uart_txd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; the word is accepted on the next posedge.
  task automatic push_word(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge sys_clk);
    @(negedge sys_clk);
    tx_valid = 1'b0;
  endtask

  // Samples every cycle of nb bit times; one comparison per bit time.
  task automatic run_line(input string nm, input logic [11:0] line, input int nb,
                          output logic bprev, output logic blast);
    logic bad, got;
    bprev = 1'b0;
    blast = 1'b0;
    for (int s = 0; s < nb; s++) begin
      bad = 1'b0;
      got = line[s];
      for (int j = 0; j < BPS; j++) begin
        @(negedge sys_clk);
        if (uart_txd !== line[s]) begin bad = 1'b1; got = uart_txd; end
        if (s == nb - 1 && j == BPS - 2) bprev = tx_busy;
        if (s == nb - 1 && j == BPS - 1) blast = tx_busy;
      end
      n_cmp++;
      if (bad) begin
        n_bad++;
        $display("FAIL %s slot %0d: txd got %0b, expected %0b", nm, s, got, line[s]);
      end
    end
  endtask

  // Independent 8N1 receiver used for the burst test.
  logic       rx_en = 1'b0;
  logic       rx_prev = 1'b1;
  logic [8:0] rx_q[$];
  initial begin
    logic [7:0] rb;
    logic       sb;
    forever begin
      @(negedge sys_clk);
      if (rx_prev && !uart_txd) begin
        repeat (5) @(negedge sys_clk);
        rb = '0;
        for (int b = 0; b < 8; b++) begin
          repeat (BPS) @(negedge sys_clk);
          rb[b] = uart_txd;
        end
        repeat (BPS) @(negedge sys_clk);
        sb = uart_txd;
        if (rx_en) rx_q.push_back({!sb, rb});
        rx_prev = uart_txd;
      end else begin
        rx_prev = uart_txd;
      end
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pm;
    logic        s2;
    logic [11:0] line;
    int          nb;
  } vec_t;

  vec_t vec[7];

  initial begin
    logic bp, bl;
    int   acc_cyc[18];
    int   na, guard, zeros;
    logic rdy;

    // line patterns, slot 0 = start bit
    vec[0] = '{8'hA5, 2'b00, 1'b0, 12'h34A, 10}; // 0,1,0,1,0,0,1,0,1,1
    vec[1] = '{8'h07, 2'b10, 1'b0, 12'h60E, 11}; // even parity bit 1
    vec[2] = '{8'h07, 2'b01, 1'b0, 12'h40E, 11}; // odd parity bit 0
    vec[3] = '{8'h00, 2'b00, 1'b1, 12'h600, 11}; // two stop bits
    vec[4] = '{8'hFF, 2'b00, 1'b1, 12'h7FE, 11};
    vec[5] = '{8'h3C, 2'b11, 1'b0, 12'h278, 10}; // mode 11 = no parity
    vec[6] = '{8'h5A, 2'b01, 1'b1, 12'hEB4, 12}; // odd parity 1, two stops

    // ---- reset state
    #1 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_level", fifo_level, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // ---- single frames from idle
    for (int v = 0; v < 7; v++) begin
      parity_mode = vec[v].pm;
      stop2       = vec[v].s2;
      push_word(vec[v].data);
      chk($sformatf("v%0d_level_acc", v), fifo_level, 1);
      chk($sformatf("v%0d_txd_k", v), uart_txd, 1);
      @(negedge sys_clk);
      chk($sformatf("v%0d_txd_k1", v), uart_txd, 1);
      // settings changed mid-frame must not affect this frame
      parity_mode = ~vec[v].pm;
      stop2       = ~vec[v].s2;
      run_line($sformatf("v%0d", v), vec[v].line, vec[v].nb, bp, bl);
      chk($sformatf("v%0d_busy_last", v), bp, 1);
      chk($sformatf("v%0d_busy_done", v), bl, 0);
      chk($sformatf("v%0d_idle_high", v), uart_txd, 1);
      repeat (3) @(negedge sys_clk);
    end

    // ---- back-to-back, two stop bits, 220 cycles with no gap
    parity_mode = 2'b00;
    stop2       = 1'b1;
    push_word(8'h00);
    push_word(8'hFF);
    chk("b2b_level", fifo_level, 1);
    run_line("b2b0", vec[3].line, 11, bp, bl);
    chk("b2b_busy_between", bl, 1);
    chk("b2b_level_popped", fifo_level, 0);
    run_line("b2b1", vec[4].line, 11, bp, bl);
    chk("b2b_busy_done", bl, 0);
    repeat (3) @(negedge sys_clk);

    // ---- burst of 18 words with tx_valid held high
    stop2 = 1'b0;
    rx_q.delete();
    rx_en    = 1'b1;
    na       = 0;
    guard    = 0;
    tx_valid = 1'b1;
    tx_data  = 8'h40;
    while (na < 18 && guard < 400) begin
      rdy = tx_ready;
      @(posedge sys_clk);
      guard++;
      if (rdy) begin acc_cyc[na] = guard; na++; end
      @(negedge sys_clk);
      if (rdy && na == 17) begin
        chk("burst_level_full", fifo_level, 16);
        chk("burst_ready_low", tx_ready, 0);
      end
      if (na < 18) tx_data = 8'h40 + 8'(na);
      else         tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    chk("burst_accepted", na, 18);
    if (na == 18) begin
      chk("burst_17th_no_stall", acc_cyc[16] - acc_cyc[0], 16);
      chk("burst_18th_after_pop", acc_cyc[17] - acc_cyc[0], 102);
    end
    guard = 0;
    while (rx_q.size() < 18 && guard < 2500) begin
      @(negedge sys_clk);
      guard++;
    end
    chk("burst_rx_count", rx_q.size(), 18);
    for (int i = 0; i < 18 && i < rx_q.size(); i++)
      chk($sformatf("burst_rx%0d", i), rx_q[i], {1'b0, 8'h40 + 8'(i)});
    rx_en = 1'b0;
    repeat (30) @(negedge sys_clk);
    chk("burst_busy_done", tx_busy, 0);

`ifdef UART_TX_BREAK_EN
    // ---- break: 200 low, >=10 high, then the queued word unchanged
    begin
      int         lo, hi, g;
      logic [4:0] lvl_mid;
      logic [7:0] rb;
      parity_mode = 2'b00;
      stop2       = 1'b0;
      lvl_mid     = '0;
      send_break  = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      send_break = 1'b0;
      g = 0;
      while (uart_txd && g < 5) begin @(negedge sys_clk); g++; end
      lo = 0;
      while (!uart_txd && lo < 400) begin
        lo++;
        if (lo == 50) begin tx_valid = 1'b1; tx_data = 8'hA5; end
        else if (lo == 51) tx_valid = 1'b0;
        if (lo == 100) lvl_mid = fifo_level;
        @(negedge sys_clk);
      end
      tx_valid = 1'b0;
      chk("brk_low_len", lo, 200);
      chk("brk_fifo_held", lvl_mid, 1);
      hi = 0;
      while (uart_txd && hi < 50) begin hi++; @(negedge sys_clk); end
      chk("brk_high_min", 32'(hi >= 10), 1);
      chk("brk_high_bounded", 32'(hi < 50), 1);
      repeat (5) @(negedge sys_clk);
      chk("brk_start", uart_txd, 0);
      rb = '0;
      for (int b = 0; b < 8; b++) begin
        repeat (BPS) @(negedge sys_clk);
        rb[b] = uart_txd;
      end
      repeat (BPS) @(negedge sys_clk);
      chk("brk_stop", uart_txd, 1);
      chk("brk_word", rb, 8'hA5);
      repeat (20) @(negedge sys_clk);
    end
`endif

    // ---- reset in the middle of a frame
    parity_mode = 2'b00;
    stop2       = 1'b0;
    push_word(8'h00);
    push_word(8'h66);
    repeat (35) @(negedge sys_clk);
    chk("mid_txd_low", uart_txd, 0);
    chk("mid_level", fifo_level, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_txd", uart_txd, 1);
    chk("arst_ready", tx_ready, 1);
    chk("arst_level", fifo_level, 0);
    chk("arst_busy", tx_busy, 0);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    zeros = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (!uart_txd) zeros++;
    end
    chk("post_rst_no_frame", zeros, 0);
    chk("post_rst_busy", tx_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
